// File: rtl/alu_serial_sequencer.sv
// Bit-serial controller that walks one external 1-bit ALU slice across a WIDTH-bit word.
// One slice cycle per bit, plus one extra cycle for SLT to resolve the sign through the slice.
module alu_serial_sequencer #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic             alu_less,
  output logic [2:0]       alu_ctl,
  input  logic             alu_dout,
  input  logic             alu_cout
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SLT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]       op_q, op_d, alu_ctl_q, alu_ctl_d;
  logic [IDXW-1:0]  idx_q, idx_d, idx_inc;
  logic             carry_q, carry_d;
  logic             done_q, done_d, zero_q, zero_d, overflow_q, overflow_d;
  logic             illegal_q, illegal_d;
  logic             alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_cin_q, alu_cin_d;
  logic             alu_less_q, alu_less_d;
  logic             op_legal, ovf_bit, is_arith;

  assign op_legal = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
                    (op == OP_SUB) || (op == OP_SLT);
  assign idx_inc  = idx_q + 1'b1;
  assign ovf_bit  = alu_cin_q ^ alu_cout;
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  // Slice inputs are registered: each cycle's values are computed from the next state.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    done_d     = 1'b0;
    alu_a_d    = 1'b0;
    alu_b_d    = 1'b0;
    alu_cin_d  = 1'b0;
    alu_less_d = 1'b0;
    alu_ctl_d  = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          zero_d     = 1'b0;
          overflow_d = 1'b0;
          illegal_d  = 1'b0;
          if (op_legal) begin
            state_d   = S_RUN;
            a_d       = a;
            b_d       = b;
            op_d      = op;
            idx_d     = '0;
            carry_d   = op[2];
            alu_a_d   = a[0];
            alu_b_d   = b[0];
            alu_cin_d = op[2];
            alu_ctl_d = (op == OP_SLT) ? OP_SUB : op;
          end else begin
            state_d   = S_DONE;
            result_d  = '0;
            illegal_d = 1'b1;
            done_d    = 1'b1;
          end
        end
      end
      S_RUN: begin
        result_d[idx_q] = alu_dout;
        carry_d         = alu_cout;
        if (idx_q == LAST_IDX) begin
          if (op_q == OP_SLT) begin
            state_d    = S_SLT;
            alu_ctl_d  = OP_SLT;
            // True sign of a-b is the sum MSB corrected by signed overflow.
            alu_less_d = alu_dout ^ ovf_bit;
          end else begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            overflow_d = is_arith & ovf_bit;
            zero_d     = (result_d == '0);
          end
        end else begin
          idx_d     = idx_inc;
          alu_a_d   = a_q[idx_inc];
          alu_b_d   = b_q[idx_inc];
          alu_cin_d = alu_cout;
          alu_ctl_d = alu_ctl_q;
        end
      end
      S_SLT: begin
        state_d    = S_DONE;
        result_d   = {{(WIDTH-1){1'b0}}, alu_dout};
        zero_d     = ~alu_dout;
        overflow_d = 1'b0;
        done_d     = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      done_q     <= 1'b0;
      alu_a_q    <= 1'b0;
      alu_b_q    <= 1'b0;
      alu_cin_q  <= 1'b0;
      alu_less_q <= 1'b0;
      alu_ctl_q  <= 3'b000;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
      done_q     <= done_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_cin_q  <= alu_cin_d;
      alu_less_q <= alu_less_d;
      alu_ctl_q  <= alu_ctl_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;
  assign illegal  = illegal_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_cin  = alu_cin_q;
  assign alu_less = alu_less_q;
  assign alu_ctl  = alu_ctl_q;

  logic unused_carry;
  assign unused_carry = carry_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer with a behavioural 1-bit ALU slice attached.
module tb_alu_serial_sequencer;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       op = 3'b000;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             busy, done, zero, overflow, illegal;
  logic [WIDTH-1:0] result;
  logic             alu_a, alu_b, alu_cin, alu_less, alu_dout, alu_cout;
  logic [2:0]       alu_ctl;

  int checks = 0;
  int errors = 0;

  alu_serial_sequencer #(.WIDTH(WIDTH), .IDXW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .overflow(overflow), .illegal(illegal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_less(alu_less),
    .alu_ctl(alu_ctl), .alu_dout(alu_dout), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Reference slice: ctl[2] inverts b, ctl[1:0] selects AND/OR/SUM/LESS.
  logic bb;
  always_comb begin
    bb       = alu_ctl[2] ? ~alu_b : alu_b;
    alu_cout = (alu_a & bb) | (alu_cin & (alu_a ^ bb));
    case (alu_ctl[1:0])
      2'b00:   alu_dout = alu_a & bb;
      2'b01:   alu_dout = alu_a | bb;
      2'b10:   alu_dout = alu_a ^ bb ^ alu_cin;
      default: alu_dout = alu_less;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Launches one operation; lat counts edges from the accepting edge up to done.
  // Optionally pulses a spurious start (OR of zeros) a few cycles into the run.
  task automatic run_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input bit poke, output int lat);
    op = o; a = xa; b = xb; start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      if (poke && lat == 4) begin
        start = 1'b1; op = 3'b001; a = '0; b = '0;
      end
      if (poke && lat == 5) start = 1'b0;
    end while (!done && lat < 100);
  endtask

  task automatic after_done(input string tag);
    @(posedge clk); #1;
    check_eq({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  int lat;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_flags", {29'b0, zero, overflow, illegal}, 32'd0);
    check_eq("rst_alu", {27'b0, alu_a, alu_b, alu_cin, alu_less, |alu_ctl}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'b010, 32'h7FFF_FFFF, 32'h1, 1'b0, lat);
    check_eq("add_lat", lat, 32'd33);
    check_eq("add_res", result, 32'h8000_0000);
    check_eq("add_ovf", {31'b0, overflow}, 32'd1);
    check_eq("add_zero", {31'b0, zero}, 32'd0);
    check_eq("add_alu_idle", {29'b0, alu_ctl}, 32'd0);
    after_done("add");

    run_op(3'b110, 32'd5, 32'd5, 1'b0, lat);
    check_eq("sub_eq_res", result, 32'd0);
    check_eq("sub_eq_zero", {31'b0, zero}, 32'd1);
    check_eq("sub_eq_ovf", {31'b0, overflow}, 32'd0);
    after_done("sub_eq");

    run_op(3'b110, 32'd0, 32'd1, 1'b0, lat);
    check_eq("sub_neg_res", result, 32'hFFFF_FFFF);
    check_eq("sub_neg_ovf", {31'b0, overflow}, 32'd0);
    check_eq("sub_neg_lat", lat, 32'd33);
    after_done("sub_neg");

    run_op(3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0, lat);
    check_eq("slt_m1_res", result, 32'd1);
    check_eq("slt_m1_lat", lat, 32'd34);
    check_eq("slt_m1_ovf", {31'b0, overflow}, 32'd0);
    after_done("slt_m1");

    run_op(3'b111, 32'h8000_0000, 32'd1, 1'b0, lat);
    check_eq("slt_ovf_res", result, 32'd1);
    check_eq("slt_ovf_flag", {31'b0, overflow}, 32'd0);

    @(posedge clk); #1;
    run_op(3'b111, 32'd3, 32'd2, 1'b0, lat);
    check_eq("slt_ge_res", result, 32'd0);
    check_eq("slt_ge_zero", {31'b0, zero}, 32'd1);

    @(posedge clk); #1;
    run_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, lat);
    check_eq("and_res", result, 32'hF000_F000);
    check_eq("and_lat", lat, 32'd33);
    check_eq("and_ovf", {31'b0, overflow}, 32'd0);
    after_done("and");

    run_op(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat);
    check_eq("or_res", result, 32'hFFF0_FFF0);
    check_eq("or_ovf", {31'b0, overflow}, 32'd0);
    after_done("or");

    run_op(3'b011, 32'h1234_5678, 32'h1, 1'b0, lat);
    check_eq("ill_lat", lat, 32'd1);
    check_eq("ill_flag", {31'b0, illegal}, 32'd1);
    check_eq("ill_res", result, 32'd0);
    after_done("ill");

    run_op(3'b010, 32'd2, 32'd3, 1'b0, lat);
    check_eq("add5_res", result, 32'd5);
    check_eq("add5_ill", {31'b0, illegal}, 32'd0);
    check_eq("add5_ovf", {31'b0, overflow}, 32'd0);
    after_done("add5");

    // Reset while RUN sits at bit 7.
    op = 3'b010; a = 32'hFFFF_FFFF; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check_eq("mid_busy", {31'b0, busy}, 32'd1);
    check_eq("mid_ctl", {29'b0, alu_ctl}, 32'd2);
    rst = 1'b1;
    #1;
    check_eq("arst_busy", {31'b0, busy}, 32'd0);
    check_eq("arst_result", result, 32'd0);
    check_eq("arst_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) lat++;
    end
    check_eq("arst_no_done", lat, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
